smvm_issue_scheduler: RTL and testbench
=======================================

# smvm_issue_scheduler

Input-side issue controller for the sparse matrix-vector multiply datapath. It buffers the incoming stream of matrix nonzeros (value, column index, IPV row-end flag) in a small FIFO. It packs them into K-lane bundles for the K-wide multiply/reduce ALU, with valid/ready backpressure from the ALU side. At end of matrix it flushes a zero-padded partial bundle, then signals completion. It also counts rows issued.

## Interface
- K, 4, lanes per bundle (ALU width)
- DEPTH, 8, FIFO entries; power of 2, ≥ K
- VAL_W, 8, matrix value width
- COL_W, 9, column index width

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- nz_valid  in  1  nonzero present on nz_* this cycle
- nz_ready  out  1  scheduler can accept a nonzero
- nz_val  in  VAL_W  nonzero value
- nz_col  in  COL_W  nonzero column index
- nz_ipv  in  1  last nonzero of its row
- mat_done  in  1  single-cycle pulse: no further nonzeros for this matrix
- issue_valid  out  1  bundle on issue_* is valid
- issue_ready  in  1  ALU accepts bundle
- issue_val  out  K*VAL_W  lane values; lane 0 (oldest) in MSBs
- issue_col  out  K*COL_W  lane column indices, same lane order
- issue_ipv  out  K  lane row-end flags; bit K-1 = lane 0
- issue_mask  out  K  lane-valid mask; bit K-1 = lane 0
- row_cnt  out  9  rows issued (sum of issued ipv bits), wraps mod 512
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a flush completes

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN on the first accepted nonzero.
- IDLE → FLUSH on mat_done.
- RUN → FLUSH on mat_done.
- FLUSH → DONE when the FIFO is empty and no bundle is pending, meaning issue_valid=0 or the bundle is accepted this cycle.
- DONE → IDLE unconditionally.
- Push: nz_valid && nz_ready. nz_ready = (count < DEPTH) && state ∈ {IDLE, RUN} && rst_n. Ready depends only on the current count; a pop in the same cycle does not free space for a push.
- mat_done in the same cycle as an accepted push: that entry is included in the flush.
- Load of the output register: condition (!issue_valid || issue_ready) && (count ≥ K || (state == FLUSH && count > 0)).
- On load, pop min(count, K) entries in order.
- Unfilled lanes carry val/col/ipv = 0 and mask = 0.
- Full bundle: mask = all ones.
- Simultaneous push and pop: count ← count + push − popped.
- A held bundle stays stable (all issue_* constant) while issue_valid && !issue_ready.
- row_cnt += popcount(issue_ipv) on each accepted bundle (issue_valid && issue_ready).
- row_cnt clears to 0 on the first push accepted in IDLE.
- row_cnt holds through DONE/IDLE otherwise.
- mat_done while in FLUSH or DONE is ignored. nz_valid while not ready is ignored.

## Timing
- Reset (rst_n low at posedge): FIFO emptied, state IDLE, and all outputs 0: issue_*, row_cnt, busy, done. nz_ready is 0 while rst_n is low.
- Reset mid-operation discards buffered and held data; no done pulse.
- Latency: the K-th entry is pushed at edge t. The load occurs at t+1 and issue_valid is high after t+1.
- Throughput: one bundle per cycle while count ≥ K and issue_ready = 1.
- FIFO full with issue_ready = 0: nz_ready low until the bundle is accepted and entries are popped.
- mat_done with an empty FIFO and no pending bundle: FLUSH for 1 cycle, DONE (done=1) the next, then IDLE.
- done is high exactly for the cycle in which state == DONE.

## Configuration
- SMVM_SCHED_STALL_CNT_EN defined:
  - adds output port stall_cnt (16 bits);
  - it increments each cycle issue_valid && !issue_ready, saturating at 0xFFFF;
  - it clears on reset and on the first push accepted in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Push 8 nonzeros back-to-back (values 1..8, ipv set on 4th and 8th), issue_ready=1 → two bundles, mask 1111, lane 0 = 1 then 5; row_cnt = 2.
- Push 5 nonzeros, then mat_done → bundle {1,2,3,4} then bundle with lane 0 = 5, mask 1000, lanes 1–3 zero; done pulses once; state returns to IDLE; busy 0.
- issue_ready=0, offer 12 nonzeros → first bundle held stable; FIFO holds 8 more entries, nz_ready=0 with 8 entries buffered. Raise issue_ready → remaining bundles issue in order, no loss or duplication.
- mat_done asserted in the same cycle as the 6th accepted push → partial bundle mask 1100 containing entries 5 and 6.
- rst_n low for 1 cycle during FLUSH with 3 entries buffered → next cycle all outputs 0, no done pulse, and a new stream starts cleanly.
- mat_done in IDLE with nothing buffered → no issue_valid; done high exactly 2 cycles later; row_cnt unchanged.

Source files
------------

// File: rtl/smvm_issue_scheduler.sv
// smvm_issue_scheduler: buffers SpMV nonzeros in a FIFO and issues K-lane bundles to the ALU.
// Optional stall counter output is enabled by defining SMVM_SCHED_STALL_CNT_EN.
module smvm_issue_scheduler #(
  parameter int K     = 4,
  parameter int DEPTH = 8,
  parameter int VAL_W = 8,
  parameter int COL_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nz_valid,
  output logic               nz_ready,
  input  logic [VAL_W-1:0]   nz_val,
  input  logic [COL_W-1:0]   nz_col,
  input  logic               nz_ipv,
  input  logic               mat_done,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [K*VAL_W-1:0] issue_val,
  output logic [K*COL_W-1:0] issue_col,
  output logic [K-1:0]       issue_ipv,
  output logic [K-1:0]       issue_mask,
  output logic [8:0]         row_cnt,
  output logic               busy,
`ifdef SMVM_SCHED_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic               done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] K_CNT     = CW'(K);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state_q, state_d;

  logic [VAL_W-1:0] val_mem [DEPTH];
  logic [COL_W-1:0] col_mem [DEPTH];
  logic             ipv_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic               issue_valid_q, issue_valid_d;
  logic [K*VAL_W-1:0] issue_val_q, issue_val_d;
  logic [K*COL_W-1:0] issue_col_q, issue_col_d;
  logic [K-1:0]       issue_ipv_q, issue_ipv_d;
  logic [K-1:0]       issue_mask_q, issue_mask_d;
  logic [8:0]         row_cnt_q, row_cnt_d;

  logic               accepting;
  logic               push;
  logic               slot_free;
  logic               load;
  logic               fire;
  logic [CW-1:0]      take_n;
  logic [CW-1:0]      pop_n;
  logic [8:0]         ipv_sum;
  logic [K*VAL_W-1:0] lane_val;
  logic [K*COL_W-1:0] lane_col;
  logic [K-1:0]       lane_ipv;
  logic [K-1:0]       lane_mask;

  assign accepting = (state_q == S_IDLE) || (state_q == S_RUN);
  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign nz_ready  = rst_n && accepting && (count_q < DEPTH_CNT);
  assign push      = nz_valid && nz_ready;
  assign slot_free = !issue_valid_q || issue_ready;
  assign fire      = issue_valid_q && issue_ready;
  assign take_n    = (count_q >= K_CNT) ? K_CNT : count_q;
  assign load      = slot_free && ((count_q >= K_CNT) || ((state_q == S_FLUSH) && (count_q != '0)));
  assign pop_n     = load ? take_n : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      val_mem[wr_ptr_q] <= nz_val;
      col_mem[wr_ptr_q] <= nz_col;
      ipv_mem[wr_ptr_q] <= nz_ipv;
    end
  end

  // Lane gi reads the gi-th oldest entry; lane 0 lands in the most significant slot.
  genvar gi;
  for (gi = 0; gi < K; gi++) begin : g_lane
    logic [AW-1:0] idx;
    logic          use_lane;
    assign idx      = rd_ptr_q + AW'(gi);
    assign use_lane = (CW'(gi) < take_n);
    assign lane_val[(K-1-gi)*VAL_W +: VAL_W] = use_lane ? val_mem[idx] : '0;
    assign lane_col[(K-1-gi)*COL_W +: COL_W] = use_lane ? col_mem[idx] : '0;
    assign lane_ipv[K-1-gi]  = use_lane & ipv_mem[idx];
    assign lane_mask[K-1-gi] = use_lane;
  end

  always_comb begin
    ipv_sum = '0;
    for (int i = 0; i < K; i++) begin
      ipv_sum = ipv_sum + 9'(issue_ipv_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mat_done)  state_d = S_FLUSH;
        else if (push) state_d = S_RUN;
      end
      S_RUN: begin
        if (mat_done) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if ((count_q == '0) && slot_free) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q + AW'(push);
    rd_ptr_d      = rd_ptr_q + AW'(pop_n);
    count_d       = count_q + CW'(push) - pop_n;
    issue_valid_d = issue_valid_q;
    issue_val_d   = issue_val_q;
    issue_col_d   = issue_col_q;
    issue_ipv_d   = issue_ipv_q;
    issue_mask_d  = issue_mask_q;
    if (load) begin
      issue_valid_d = 1'b1;
      issue_val_d   = lane_val;
      issue_col_d   = lane_col;
      issue_ipv_d   = lane_ipv;
      issue_mask_d  = lane_mask;
    end else if (fire) begin
      issue_valid_d = 1'b0;
      issue_val_d   = '0;
      issue_col_d   = '0;
      issue_ipv_d   = '0;
      issue_mask_d  = '0;
    end
    row_cnt_d = row_cnt_q;
    if (push && (state_q == S_IDLE)) row_cnt_d = '0;
    else if (fire)                   row_cnt_d = row_cnt_q + ipv_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_val_q   <= '0;
      issue_col_q   <= '0;
      issue_ipv_q   <= '0;
      issue_mask_q  <= '0;
      row_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_val_q   <= issue_val_d;
      issue_col_q   <= issue_col_d;
      issue_ipv_q   <= issue_ipv_d;
      issue_mask_q  <= issue_mask_d;
      row_cnt_q     <= row_cnt_d;
    end
  end

`ifdef SMVM_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (push && (state_q == S_IDLE))                          stall_d = '0;
    else if (issue_valid_q && !issue_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign issue_valid = issue_valid_q;
  assign issue_val   = issue_val_q;
  assign issue_col   = issue_col_q;
  assign issue_ipv   = issue_ipv_q;
  assign issue_mask  = issue_mask_q;
  assign row_cnt     = row_cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_smvm_issue_scheduler.sv
// Testbench for smvm_issue_scheduler: vector table, directed corner sequences and
// randomized streams checked against a chunk-of-K transaction model.
module tb_smvm_issue_scheduler;

  logic        clk = 0;
  logic        rst_n;
  logic        nz_valid;
  logic        nz_ready;
  logic [7:0]  nz_val;
  logic [8:0]  nz_col;
  logic        nz_ipv;
  logic        mat_done;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_val;
  logic [35:0] issue_col;
  logic [3:0]  issue_ipv;
  logic [3:0]  issue_mask;
  logic [8:0]  row_cnt;
  logic        busy;
  logic        done;
`ifdef SMVM_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] last_row = '0;

  smvm_issue_scheduler #(.K(4), .DEPTH(8), .VAL_W(8), .COL_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col), .nz_ipv(nz_ipv),
    .mat_done(mat_done),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_val(issue_val),
    .issue_col(issue_col), .issue_ipv(issue_ipv), .issue_mask(issue_mask),
    .row_cnt(row_cnt), .busy(busy),
`ifdef SMVM_SCHED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  val;
    logic        ipv;
    logic        md;
    logic        rdy;
    logic        e_valid;
    logic [3:0]  e_mask;
    logic [31:0] e_val;
    logic [3:0]  e_ipv;
    logic [8:0]  e_row;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [7:0] v;
    logic [8:0] c;
    logic       ipv;
  } ent_t;

  typedef struct packed {
    logic [31:0] v;
    logic [35:0] c;
    logic [3:0]  ipv;
    logic [3:0]  m;
  } bun_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [7:0] val, logic ipv, logic md, logic rdy,
                              logic ev, logic [3:0] em, logic [31:0] eval, logic [3:0] eipv,
                              logic [8:0] erow, logic edone, logic ebusy);
    vec_t t;
    t.v = v; t.val = val; t.ipv = ipv; t.md = md; t.rdy = rdy;
    t.e_valid = ev; t.e_mask = em; t.e_val = eval; t.e_ipv = eipv;
    t.e_row = erow; t.e_done = edone; t.e_busy = ebusy;
    return t;
  endfunction

  // Pushes n random nonzeros, ends the matrix, and compares the accepted bundles with
  // the pushed stream cut into groups of 4 (last group zero-padded).
  task automatic stream_test(input int n, input bit md_same, input int rdy_pct, input int gap_pct);
    ent_t sent[$];
    bun_t got[$];
    bun_t cur, prev, ex;
    ent_t e;
    int i, cyc, done_cnt, tail, nb, k;
    bit md_sent, acc_push, acc_bun, held;
    logic [8:0] exp_row;
    i = 0; cyc = 0; done_cnt = 0; tail = -1; md_sent = 0; held = 0; exp_row = '0;
    prev = '0;
    while (cyc < 3000 && tail != 0) begin
      issue_ready = ($urandom_range(99) < rdy_pct);
      nz_valid    = (i < n) && ($urandom_range(99) >= gap_pct);
      nz_val      = 8'($urandom);
      nz_col      = 9'($urandom);
      nz_ipv      = 1'($urandom);
      mat_done    = 0;
      #1;
      if (!md_sent) begin
        if (md_same) mat_done = (i == n - 1) && nz_valid && nz_ready;
        else         mat_done = (i == n);
      end
      acc_push = nz_valid && nz_ready;
      acc_bun  = issue_valid && issue_ready;
      cur = {issue_val, issue_col, issue_ipv, issue_mask};
      if (held) chk("hold_stable", cur, prev);
      held = issue_valid && !issue_ready;
      prev = cur;
      e.v = nz_val; e.c = nz_col; e.ipv = nz_ipv;
      step();
      cyc++;
      if (acc_push) begin
        sent.push_back(e);
        i++;
      end
      if (mat_done) md_sent = 1;
      if (acc_bun) got.push_back(cur);
      if (done) done_cnt++;
      if (tail > 0) tail--;
      else if (tail < 0 && done) tail = 3;
    end
    nz_valid = 0; mat_done = 0;
    chk("stream_completed", tail == 0, 1);
    chk("stream_pushes", sent.size(), n);
    nb = (n + 3) / 4;
    chk("bundle_count", got.size(), nb);
    for (int b = 0; b < nb; b++) begin
      ex = '0;
      for (int j = 0; j < 4; j++) begin
        k = b * 4 + j;
        if (k < sent.size()) begin
          ex.v[(3-j)*8 +: 8] = sent[k].v;
          ex.c[(3-j)*9 +: 9] = sent[k].c;
          ex.ipv[3-j]        = sent[k].ipv;
          ex.m[3-j]          = 1'b1;
        end
      end
      if (b < got.size()) chk("bundle_content", got[b], ex);
    end
    foreach (sent[s]) exp_row = exp_row + 9'(sent[s].ipv);
    chk("stream_done_pulses", done_cnt, 1);
    chk("stream_row_cnt", row_cnt, exp_row);
    chk("stream_idle_busy", busy, 0);
    last_row = exp_row;
  endtask

  initial begin
    vec_t tbl[22];
    logic [31:0] got3[$];
    int i, cyc;
    bit acc, seen;

    tbl[0]  = mk(1, 1, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[1]  = mk(1, 2, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[2]  = mk(1, 3, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[3]  = mk(1, 4, 1, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[4]  = mk(1, 5, 0, 0, 1, 1, 4'hF, 32'h01020304, 4'b0001, 0, 0, 1);
    tbl[5]  = mk(1, 6, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 1, 0, 1);
    tbl[6]  = mk(1, 7, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 1, 0, 1);
    tbl[7]  = mk(1, 8, 1, 0, 1, 0, 4'h0, 32'h0, 4'h0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 4'hF, 32'h05060708, 4'b0001, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 2, 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 1, 0, 4'h0, 32'h0, 4'h0, 2, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 2, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 2, 0, 0);
    tbl[13] = mk(1, 1, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[14] = mk(1, 2, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[15] = mk(1, 3, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[16] = mk(1, 4, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[17] = mk(1, 5, 1, 0, 1, 1, 4'hF, 32'h01020304, 4'b0000, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 1, 1, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 1, 1, 4'b1000, 32'h05000000, 4'b1000, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 1, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 4'h0, 1, 0, 0);

    rst_n = 0; nz_valid = 0; nz_val = 0; nz_col = 0; nz_ipv = 0; mat_done = 0; issue_ready = 0;
    step(); step();
    chk("rst_outputs", {issue_valid, issue_val, issue_col, issue_ipv, issue_mask, row_cnt, busy, done}, '0);
    chk("rst_nz_ready", nz_ready, 0);
    rst_n = 1;
    #1;
    chk("idle_nz_ready", nz_ready, 1);

    // Two full bundles, then a 5-entry matrix with a zero-padded flush.
    for (int t = 0; t < 22; t++) begin
      nz_valid = tbl[t].v; nz_val = tbl[t].val; nz_col = 9'(tbl[t].val) + 9'd100;
      nz_ipv = tbl[t].ipv; mat_done = tbl[t].md; issue_ready = tbl[t].rdy;
      step();
      $display("vec %0d: valid=%0b val=%h mask=%b row=%0d done=%0b busy=%0b",
               t, issue_valid, issue_val, issue_mask, row_cnt, done, busy);
      chk("vec_valid", issue_valid, tbl[t].e_valid);
      chk("vec_row_cnt", row_cnt, tbl[t].e_row);
      chk("vec_done", done, tbl[t].e_done);
      chk("vec_busy", busy, tbl[t].e_busy);
      if (tbl[t].e_valid)
        chk("vec_bundle", {issue_mask, issue_val, issue_ipv}, {tbl[t].e_mask, tbl[t].e_val, tbl[t].e_ipv});
    end
    nz_valid = 0; mat_done = 0;

    // Backpressure: 12 offered with issue_ready low.
    issue_ready = 0; i = 1; cyc = 0;
    while (i <= 12 && cyc < 100) begin
      nz_valid = 1; nz_val = 8'(i); nz_col = 9'(i); nz_ipv = (i % 4 == 0);
      #1;
      acc = nz_ready;
      step();
      if (acc) i++;
      cyc++;
      if (issue_valid) chk("bp_held_bundle", {issue_mask, issue_val}, {4'hF, 32'h01020304});
    end
    nz_valid = 0;
    chk("bp_all_accepted", i, 13);
    step(); step(); step();
    chk("bp_nz_ready_full", nz_ready, 0);
    chk("bp_held_valid", issue_valid, 1);
    chk("bp_held_data", {issue_mask, issue_val, issue_ipv}, {4'hF, 32'h01020304, 4'b0001});
    issue_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (issue_valid && issue_ready) got3.push_back(issue_val);
      step();
    end
    $display("backpressure drain: %0d bundles", got3.size());
    chk("bp_bundle_count", got3.size(), 3);
    if (got3.size() == 3) begin
      chk("bp_bundle0", got3[0], 32'h01020304);
      chk("bp_bundle1", got3[1], 32'h05060708);
      chk("bp_bundle2", got3[2], 32'h090A0B0C);
    end
    chk("bp_row_cnt", row_cnt, 3);
    mat_done = 1;
    step();
    mat_done = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (done) seen = 1;
      else step();
    end
    chk("bp_done_seen", seen, 1);
    step();

    // mat_done with the 6th accepted push: partial bundle holds entries 5 and 6.
    stream_test(6, 1, 100, 0);
    $display("mat_done with 6th push: checked");

    // Reset during FLUSH with 3 entries buffered.
    issue_ready = 1;
    for (int v = 1; v <= 3; v++) begin
      nz_valid = 1; nz_val = 8'(v); nz_col = 9'(v); nz_ipv = 1;
      step();
    end
    nz_valid = 0; mat_done = 1;
    step();
    mat_done = 0;
    chk("flush_busy", busy, 1);
    rst_n = 0; issue_ready = 0;
    #1;
    chk("rst_mid_nz_ready", nz_ready, 0);
    step();
    chk("rst_mid_outputs", {issue_valid, issue_val, issue_col, issue_ipv, issue_mask, row_cnt, busy, done}, '0);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_mid_quiet", {done, issue_valid, busy}, 3'b000);
    end
    $display("reset during flush: checked");
    stream_test(5, 0, 100, 0);

    // mat_done in IDLE with nothing buffered.
    issue_ready = 1; mat_done = 1;
    step();
    mat_done = 0;
    chk("empty_flush_c1", {done, issue_valid, busy}, 3'b001);
    step();
    chk("empty_flush_c2", {done, issue_valid, busy}, 3'b101);
    step();
    chk("empty_flush_c3", {done, busy}, 2'b00);
    chk("empty_flush_row", row_cnt, last_row);
    $display("empty mat_done: checked");

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 30);
      stream_test(n, 1'($urandom_range(1)), $urandom_range(20, 100), $urandom_range(0, 60));
      $display("random stream %0d: n=%0d", r, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
